reg_file_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor to the single-write, two-read 32x32 file in the pipelined CPU datapath.
- Generalised in width, depth and port count.
- Adds correct enable-qualified write-through bypass, deterministic write-port priority, and a hardware clear sequencer (multi-cycle FSM) for flush/context reset without asserting global reset.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_rd_port.sv | 51 +++++
 rtl/reg_file_mp.sv | 111 +++++++++++
 tb/tb_reg_file_mp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// reg_file_pkg: shared clear-FSM state type, default geometry and depth helper
// for the multi-port register file (optional bypass macro: REG_FILE_BYPASS_EN).
package reg_file_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// reg_file_rd_port: one combinational read port with address-0 forcing and,
// when REG_FILE_BYPASS_EN is defined, a priority write-through bypass mux.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        array_data,
   input  logic [NUM_WR-1:0]        fwd_en,
   input  logic [NUM_WR*ADDR_W-1:0] fwd_addr,
   input  logic [NUM_WR*DATA_W-1:0] fwd_data,
   output logic [DATA_W-1:0]        data
);

   logic addr_is_zero;
   assign addr_is_zero = (addr == '0);

`ifdef REG_FILE_BYPASS_EN
   // Ascending scan so the highest-indexed matching port wins, as in the write path.
   always_comb begin
      data = array_data;
      if (!addr_is_zero) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (fwd_en[w] && (fwd_addr[w*ADDR_W +: ADDR_W] == addr)) begin
               data = fwd_data[w*DATA_W +: DATA_W];
            end
         end
      end
      if ((ZERO_REG != 0) && addr_is_zero) begin
         data = '0;
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};

   always_comb begin
      data = array_data;
      if ((ZERO_REG != 0) && addr_is_zero) begin
         data = '0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// reg_file_mp: parametrised multi-port register file with write priority,
// hardware clear sequencer and optional bypass (macro REG_FILE_BYPASS_EN).
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic                     clear_req_i,
   output logic                     clear_busy_o,
   output logic                     wr_drop_o
);

   localparam int                DEPTH     = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] FIRST_CLR = ADDR_W'((ZERO_REG != 0) ? 1 : 0);

   logic [DATA_W-1:0] mem [DEPTH];
   clr_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              busy_q;
   logic              drop_q;
   logic              idle;
   logic              drop_next;
   logic [NUM_WR-1:0] wr_zero;
   logic [NUM_WR-1:0] fwd_en;

   assign idle = (state == ST_IDLE);

   generate
      for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_qual
         assign wr_zero[w] = (ZERO_REG != 0) && (wr_addr_i[w*ADDR_W +: ADDR_W] == '0);
         assign fwd_en[w]  = wr_en_i[w] & idle;
      end
   endgenerate

   // While clearing every enabled write is discarded; in idle only reg-0 writes are.
   assign drop_next = idle ? |(wr_en_i & wr_zero) : |wr_en_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         state   <= ST_IDLE;
         clr_cnt <= '0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= drop_next;
         if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
            if (clr_cnt == LAST_ADDR) begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end else begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
            end
         end else begin
            // Later ports overwrite earlier ones on an address collision.
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_en_i[w] && !wr_zero[w]) begin
                  mem[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
               end
            end
            if (clear_req_i) begin
               state   <= ST_CLEAR;
               clr_cnt <= FIRST_CLR;
               busy_q  <= 1'b1;
            end
         end
      end
   end

   assign clear_busy_o = busy_q;
   assign wr_drop_o    = drop_q;

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
         logic [DATA_W-1:0] array_data;
         assign array_data = mem[rd_addr_i[p*ADDR_W +: ADDR_W]];

         reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
         ) u_rd_port (
            .addr       (rd_addr_i[p*ADDR_W +: ADDR_W]),
            .array_data (array_data),
            .fwd_en     (fwd_en),
            .fwd_addr   (wr_addr_i),
            .fwd_data   (wr_data_i),
            .data       (rd_data_o[p*DATA_W +: DATA_W])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// tb_reg_file_mp: randomized + directed scoreboard bench for reg_file_mp
// against an array-based reference model (honours REG_FILE_BYPASS_EN).
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int DEPTH = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [NRD*AW-1:0]  rd_addr;
   logic [NRD*DW-1:0]  rd_data;
   logic [NWR-1:0]     wr_en;
   logic [NWR*AW-1:0]  wr_addr;
   logic [NWR*DW-1:0]  wr_data;
   logic               clear_req;
   logic               clear_busy;
   logic               wr_drop;

   always #5 clk = ~clk;

   reg_file_mp #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NRD),
      .NUM_WR   (NWR),
      .ZERO_REG (1)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .clear_req_i  (clear_req),
      .clear_busy_o (clear_busy),
      .wr_drop_o    (wr_drop)
   );

   typedef struct {
      int          src;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   int          busy_hi      = 0;

   // Reference model: plain array plus "clearing" flag and next index to wipe.
   logic [31:0] m_mem [DEPTH];
   bit          m_busy;
   bit          m_drop;
   int          m_idx;

   function automatic string src_name(input int s);
      case (s)
         0:       return "rd_data0";
         1:       return "rd_data1";
         2:       return "clear_busy";
         default: return "wr_drop";
      endcase
   endfunction

   initial begin : monitor
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         if (clear_busy) busy_hi++;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.src)
               0:       act = rd_data[31:0];
               1:       act = rd_data[63:32];
               2:       act = {31'b0, clear_busy};
               default: act = {31'b0, wr_drop};
            endcase
            tests_run++;
            if (act !== e.exp) begin
               tests_failed++;
               $display("FAIL %s cycle %0d: got %h expected %h", src_name(e.src), cyc, act, e.exp);
            end
         end
      end
   end

   task automatic push_exp(input int s, input logic [31:0] v);
      exp_t e;
      e.src = s;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic step(input bit r, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] en, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input bit creq);
      logic [4:0]  ra [2];
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [31:0] v;
      @(posedge clk);
      #1;
      cyc++;
      rst       = r;
      rd_addr   = {ra1, ra0};
      wr_en     = en;
      wr_addr   = {wa1, wa0};
      wr_data   = {wd1, wd0};
      clear_req = creq;
      ra[0] = ra0; ra[1] = ra1;
      wa[0] = wa0; wa[1] = wa1;
      wd[0] = wd0; wd[1] = wd1;

      for (int p = 0; p < NRD; p++) begin
         if (ra[p] == 5'd0) begin
            v = 32'h0;
         end else begin
            v = m_mem[ra[p]];
`ifdef REG_FILE_BYPASS_EN
            if (!m_busy) begin
               for (int w = 0; w < NWR; w++) begin
                  if (en[w] && wa[w] == ra[p]) v = wd[w];
               end
            end
`endif
         end
         push_exp(p, v);
      end
      push_exp(2, {31'b0, m_busy});
      push_exp(3, {31'b0, m_drop});

      if (r) begin
         foreach (m_mem[i]) m_mem[i] = 32'h0;
         m_busy = 1'b0;
         m_drop = 1'b0;
         m_idx  = 0;
      end else if (m_busy) begin
         m_mem[m_idx] = 32'h0;
         m_drop = (en != 2'b00);
         if (m_idx == DEPTH - 1) m_busy = 1'b0;
         else                    m_idx++;
      end else begin
         m_drop = 1'b0;
         for (int w = 0; w < NWR; w++) begin
            if (en[w]) begin
               if (wa[w] == 5'd0) m_drop = 1'b1;
               else               m_mem[wa[w]] = wd[w];
            end
         end
         if (creq) begin
            m_busy = 1'b1;
            m_idx  = 1;
         end
      end
   endtask

   task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
      step(1'b0, ra0, ra1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic random_step();
      logic [4:0]  wa0, wa1, ra0, ra1;
      logic [1:0]  en;
      bit          r, cr;
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
      en  = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 99) == 0);
      cr  = ($urandom_range(0, 59) == 0);
      step(r, ra0, ra1, en, wa0, wa1, $urandom, $urandom, cr);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      rst       = 1'b1;
      rd_addr   = '0;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      clear_req = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_idx  = 0;

      // Post-reset sweep of all addresses.
      for (int i = 0; i < DEPTH / 2; i++) idle_read(5'(2 * i), 5'(2 * i + 1));

      // Same-cycle dual write to one address: priority and (optional) bypass.
      step(1'b0, 5'd5, 5'd6, 2'b11, 5'd5, 5'd5, 32'h1111, 32'h2222, 1'b0);
      idle_read(5'd5, 5'd5);

      // Disabled port must never forward nor write.
      step(1'b0, 5'd7, 5'd7, 2'b00, 5'd7, 5'd7, 32'hDEAD, 32'hDEAD, 1'b0);
      idle_read(5'd7, 5'd5);

      // Zero register: write dropped, drop pulse exactly one cycle.
      step(1'b0, 5'd0, 5'd0, 2'b01, 5'd0, 5'd9, 32'hFFFF_FFFF, 32'h0, 1'b0);
      idle_read(5'd0, 5'd9);
      idle_read(5'd0, 5'd0);

      // Fill 1..31 with their index, then run a full clear.
      for (int i = 0; i < DEPTH / 2; i++) begin
         step(1'b0, 5'd10, 5'd3, 2'b11, 5'(2 * i), 5'(2 * i + 1),
              32'(2 * i), 32'(2 * i + 1), 1'b0);
      end
      step(1'b0, 5'd10, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
      busy_hi = 0;
      for (int k = 0; k < 100 && m_busy; k++) begin
         if (m_idx == 5) step(1'b0, 5'd10, 5'd3, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b0);
         else            idle_read(5'd10, 5'd3);
      end
      idle_read(5'd10, 5'd3);
      @(negedge clk);
      #1;
      tests_run++;
      if (busy_hi != DEPTH - 1) begin
         tests_failed++;
         $display("FAIL clear_busy_len: got %0d cycles expected %0d", busy_hi, DEPTH - 1);
      end

      // Reset in the middle of a clear.
      for (int i = 1; i < 20; i++) step(1'b0, 5'd12, 5'd13, 2'b01, 5'(i), 5'd0, 32'(i + 100), 32'h0, 1'b0);
      step(1'b0, 5'd12, 5'd15, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
      for (int k = 0; k < 100 && m_idx != 12; k++) idle_read(5'd12, 5'd15);
      step(1'b1, 5'd15, 5'd18, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 5'd15, 5'd18, 2'b01, 5'd9, 5'd0, 32'hABCD, 32'h0, 1'b0);
      idle_read(5'd9, 5'd18);

      // Randomized traffic with occasional clears and resets.
      for (int k = 0; k < 600; k++) random_step();
      for (int k = 0; k < 40; k++) idle_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
